// File: rtl/bram_stream_reader.sv
// Streams a contiguous (wrapping) block of RAM words out on a valid/ready port.
// The RAM output pipeline is clock-enabled by ram_rden, so back-pressure freezes it in place.
module bram_stream_reader #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 9,
    parameter int C_RD_LATENCY = 1   // 1 or 3 only
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [C_ADDR_WIDTH-1:0] base_addr,
    input  logic [C_ADDR_WIDTH:0]   length,
    output logic                    busy,
    output logic                    done,
    output logic [C_ADDR_WIDTH-1:0] ram_addr,
    output logic                    ram_rden,
    input  logic [C_DATA_WIDTH-1:0] ram_dout,
    output logic                    m_valid,
    output logic [C_DATA_WIDTH-1:0] m_data,
    output logic                    m_last,
    input  logic                    m_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [C_ADDR_WIDTH-1:0] ADDR_ONE = {{(C_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_ADDR_WIDTH:0]   REM_ONE  = {{C_ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [C_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_ADDR_WIDTH:0]     rem_q, rem_d;
    logic [C_RD_LATENCY-1:0]   vld_q, vld_d;
    logic [C_RD_LATENCY-1:0]   last_q, last_d;
    logic                      done_q, done_d;

    logic                      adv;
    logic                      ins_vld;
    logic                      ins_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            vld_q   <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        vld_d    = vld_q;
        last_d   = last_q;
        done_d   = 1'b0;
        ins_vld  = 1'b0;
        ins_last = 1'b0;

        busy     = (state_q != IDLE);
        m_valid  = vld_q[C_RD_LATENCY-1];
        m_last   = last_q[C_RD_LATENCY-1];
        // Advance unless a presented word is being held back by the consumer.
        adv      = ~(m_valid & ~m_ready);
        ram_rden = busy & adv;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = base_addr;
                        rem_d   = length;
                        state_d = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (ram_rden) begin
                    ins_vld  = 1'b1;
                    ins_last = (rem_q == REM_ONE);
                    addr_d   = addr_q + ADDR_ONE;
                    rem_d    = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last tag only ever reaches the output stage here.
                if (m_valid && m_ready && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Tags move in lockstep with the RAM output pipeline.
        if (ram_rden) begin
            vld_d[0]  = ins_vld;
            last_d[0] = ins_last;
            for (int k = 1; k < C_RD_LATENCY; k++) begin
                vld_d[k]  = vld_q[k-1];
                last_d[k] = last_q[k-1];
            end
        end
    end

    assign ram_addr = addr_q;
    assign m_data   = ram_dout;
    assign done     = done_q;

endmodule
